ha_serial_sequencer: RTL and testbench

- Bit-serial adder stage directly upstream of the half-adder sum/carry cell.
- Latches two WIDTH-bit operands and walks them LSB-first through a half-adder pair: two half adders plus an OR form one full-adder bit slice, with the carry held in a flip-flop.
- Produces the full WIDTH-bit sum plus carry-out after a fixed latency, using a start/busy/done handshake.
- Feeds the tile's uo_out result path.

---
 rtl/ha_serial_sequencer_if.sv | 24 ++
 rtl/ha_serial_sequencer.sv | 94 +++++++++
 tb/tb_ha_serial_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ha_serial_sequencer_if.sv
// Start/busy/done handshake bundle for the bit-serial adder.
// Carries the optional sub input when HA_SERIAL_SUB_EN is defined.
interface ha_serial_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef HA_SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef HA_SERIAL_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/ha_serial_sequencer.sv
// Bit-serial adder: two half adders + OR per bit, LSB first, carry held in a flop.
// Define HA_SERIAL_SUB_EN to add a sub input that turns the add into a - b.
module ha_serial_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ha_serial_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_reg;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             busy_reg;
  logic             done_reg;
  logic             cout_reg;

  // Operand B and carry-in as loaded; subtraction is a + ~b + 1.
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
`ifdef HA_SERIAL_SUB_EN
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub;
`else
  assign b_load     = bus.b;
  assign carry_load = 1'b0;
`endif

  // Full-adder bit slice built from two half adders and an OR.
  logic ha1_s, ha1_c, ha2_s, ha2_c, carry_next;
  assign ha1_s      = a_sh[0] ^ b_sh[0];
  assign ha1_c      = a_sh[0] & b_sh[0];
  assign ha2_s      = ha1_s ^ carry;
  assign ha2_c      = ha1_s & carry;
  assign carry_next = ha1_c | ha2_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_reg  <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      cout_reg <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_sh     <= bus.a;
            b_sh     <= b_load;
            carry    <= carry_load;
            cnt      <= '0;
            sum_reg  <= '0;
            busy_reg <= 1'b1;
            state    <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          sum_reg <= {ha2_s, sum_reg[WIDTH-1:1]};
          carry   <= carry_next;
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          // Last bit: stop the counter at WIDTH-1 rather than letting it wrap.
          if (cnt == CW'(WIDTH - 1)) begin
            cout_reg <= carry_next;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;
endmodule

// File: tb/tb_ha_serial_sequencer.sv
// Self-checking bench: arithmetic reference model compared every cycle,
// plus directed cases with literal expected results.
module tb_ha_serial_sequencer;
  localparam int WIDTH = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  ha_serial_sequencer_if #(.WIDTH(WIDTH)) bus ();

  ha_serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: total of the operation; after k bits the sum register
  // holds the low k bits of the total in its top k positions.
  logic             m_busy, m_done, m_cout;
  logic [WIDTH-1:0] m_sum;
  int               m_k;
  int               m_total;

  always @(posedge clk or negedge rst_n) begin
    int k;
    int t;
    logic s;
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cout <= 1'b0; m_sum <= '0;
      m_k <= 0; m_total <= 0;
    end else if (m_busy) begin
      k = m_k + 1;
      m_k   <= k;
      m_sum <= WIDTH'((m_total % (1 << k)) << (WIDTH - k));
      if (k == WIDTH) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_cout <= ((m_total >> WIDTH) & 1) != 0;
      end
    end else if (bus.start) begin
      s = 1'b0;
`ifdef HA_SERIAL_SUB_EN
      s = bus.sub;
`endif
      t = s ? int'(bus.a) + ((~int'(bus.b)) & MASK) + 1 : int'(bus.a) + int'(bus.b);
      m_total <= t;
      m_busy  <= 1'b1;
      m_k     <= 0;
      m_sum   <= '0;
      m_done  <= 1'b0;
    end else begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  always @(negedge clk) begin
    n_checks++;
    if (bus.busy === m_busy && bus.done === m_done && bus.sum === m_sum && bus.cout === m_cout)
      n_pass++;
    else
      $display("FAIL model_cycle t=%0t: busy/done/sum/cout got %b/%b/%0d/%b, expected %b/%b/%0d/%b",
               $time, bus.busy, bus.done, bus.sum, bus.cout, m_busy, m_done, m_sum, m_cout);
  end

  task automatic set_ops(input int av, input int bv, input bit sv);
    bus.a = WIDTH'(av);
    bus.b = WIDTH'(bv);
`ifdef HA_SERIAL_SUB_EN
    bus.sub = sv;
`else
    if (sv) $display("note: sub requested without HA_SERIAL_SUB_EN");
`endif
  endtask

  // Pulse start for one edge, then wait (bounded) for done. n = cycles to done.
  task automatic run_op(input int av, input int bv, input bit sv, output int n);
    @(posedge clk); #1;
    bus.start = 1'b1;
    set_ops(av, bv, sv);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 4'($urandom);
    bus.b = 4'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 20);
    if (n >= 20) chk("done_timeout", 0, 1);
    $display("op a=%0d b=%0d sub=%0d -> sum=%0d cout=%0d after %0d cycles",
             av, bv, sv, bus.sum, bus.cout, n);
  endtask

  initial begin
    int n;
    int dones;
    int busy_cycles;
    n_checks = 0;
    n_pass   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    set_ops(0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_sum",  int'(bus.sum),  0);
    chk("reset_cout", int'(bus.cout), 0);
    rst_n = 1'b1;

    // 5 + 3: busy 4 cycles, done on cycle 5
    run_op(5, 3, 1'b0, n);
    chk("lat_5p3",   n, 5);
    chk("sum_5p3",   int'(bus.sum), 8);
    chk("cout_5p3",  int'(bus.cout), 0);
    chk("model_5p3", int'(m_sum), 8);

    // 15 + 1 overflow, result holds afterwards
    run_op(15, 1, 1'b0, n);
    chk("sum_15p1",  int'(bus.sum), 0);
    chk("cout_15p1", int'(bus.cout), 1);
    repeat (3) @(negedge clk);
    chk("hold_sum",  int'(bus.sum), 0);
    chk("hold_cout", int'(bus.cout), 1);

    // 9 + 6 with starts during busy ignored
    @(posedge clk); #1;
    bus.start = 1'b1; set_ops(9, 6, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    dones = 0; busy_cycles = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        dones++;
        chk("sum_9p6",  int'(bus.sum), 15);
        chk("cout_9p6", int'(bus.cout), 0);
      end
      bus.start = (i == 2 || i == 3);
      if (i == 2 || i == 3) set_ops(3, 3, 1'b0);
    end
    chk("single_done", dones, 1);
    chk("busy_len",    busy_cycles, 4);

    // Back-to-back: start held through DONE
    @(posedge clk); #1;
    bus.start = 1'b1; set_ops(7, 7, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < 20);
    chk("sum_7p7",  int'(bus.sum), 14);
    chk("cout_7p7", int'(bus.cout), 0);
    set_ops(2, 2, 1'b0);
    @(posedge clk); #1;
    chk("b2b_busy", int'(bus.busy), 1);
    chk("b2b_done", int'(bus.done), 0);
    bus.start = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < 20);
    chk("lat_b2b", n, 5);
    chk("sum_2p2", int'(bus.sum), 4);

    // Reset during shift aborts
    @(posedge clk); #1;
    bus.start = 1'b1; set_ops(12, 12, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_sum",  int'(bus.sum),  0);
    chk("abort_cout", int'(bus.cout), 0);
    #1 rst_n = 1'b1;
    dones = 0;
    repeat (8) begin @(negedge clk); if (bus.done) dones++; end
    chk("abort_no_done", dones, 0);
    run_op(1, 1, 1'b0, n);
    chk("sum_1p1", int'(bus.sum), 2);

`ifdef HA_SERIAL_SUB_EN
    run_op(3, 5, 1'b1, n);
    chk("sum_3m5",  int'(bus.sum), 14);
    chk("cout_3m5", int'(bus.cout), 0);
    run_op(5, 3, 1'b1, n);
    chk("sum_5m3",  int'(bus.sum), 2);
    chk("cout_5m3", int'(bus.cout), 1);
`endif

    // Random traffic: random starts (incl. during busy) and rare resets
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      bus.start = ($urandom_range(0, 2) == 0);
      set_ops(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1'($urandom));
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    bus.start = 1'b0;
    repeat (8) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
